// File: rtl/health_tracker_pkg.sv
// Shared definitions for the health tracker and the LED display path:
// game-outcome state encodings and the default health limits.
package health_tracker_pkg;

   localparam int PLAYER_MAX_DEF = 3;
   localparam int BOSS_MAX_DEF   = 6;
   localparam int INV_TICKS_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PLAY = 3'd1,
      ST_BOSS = 3'd2,
      ST_LOSE = 3'd3,
      ST_WIN  = 3'd4
   } state_e;

endpackage

// File: rtl/health_tracker_invuln_timer.sv
// Post-hit invulnerability window: an 8-bit down-counter paced by frame ticks.
module invuln_timer
   import health_tracker_pkg::*;
#(
   parameter int INV_TICKS = INV_TICKS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   input  logic tick,
   output logic active
);

   logic [7:0] cnt_q;

   // A load in the same cycle as a tick must win, so it is tested first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= 8'(INV_TICKS);
      end else if (tick && cnt_q != 8'd0) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   assign active = (cnt_q != 8'd0);

endmodule

// File: rtl/health_tracker.sv
// Owns player/boss health for the LED display and runs the game-outcome FSM.
module health_tracker
   import health_tracker_pkg::*;
#(
   parameter int PLAYER_MAX = PLAYER_MAX_DEF,
   parameter int BOSS_MAX   = BOSS_MAX_DEF,
   parameter int INV_TICKS  = INV_TICKS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       player_hit,
   input  logic       heal,
   input  logic       boss_spawn,
   input  logic       boss_hit,
   output logic [1:0] health,
   output logic [2:0] boss_health,
   output logic       boss,
   output logic       invuln,
   output logic       game_over,
   output logic       victory
);

   localparam logic [1:0] P_MAX = 2'(PLAYER_MAX);
   localparam logic [2:0] B_MAX = 3'(BOSS_MAX);

   state_e     state_q, state_d;
   logic [1:0] health_q, health_d;
   logic [2:0] boss_health_q, boss_health_d;
   logic       boss_q, boss_d;
   logic       game_over_q, victory_q;
   logic       hit_ok, inv_load, inv_clear;

   invuln_timer #(.INV_TICKS(INV_TICKS)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (inv_load),
      .clear  (inv_clear),
      .tick   (tick),
      .active (invuln)
   );

   assign hit_ok = player_hit & ~invuln;

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d       = state_q;
      health_d      = health_q;
      boss_health_d = boss_health_q;
      boss_d        = boss_q;
      inv_load      = 1'b0;
      inv_clear     = 1'b0;
      case (state_q)
         ST_IDLE, ST_LOSE, ST_WIN: begin
            if (start) begin
               state_d       = ST_PLAY;
               health_d      = P_MAX;
               boss_d        = 1'b0;
               boss_health_d = '0;
               inv_clear     = 1'b1;
            end
         end
         ST_PLAY, ST_BOSS: begin
            inv_load = hit_ok;
            // A hit and a heal together cancel out.
            if (hit_ok && !heal) begin
               health_d = health_q - 2'd1;
            end else if (heal && !hit_ok && health_q < P_MAX) begin
               health_d = health_q + 2'd1;
            end
            if (state_q == ST_PLAY && boss_spawn) begin
               state_d       = ST_BOSS;
               boss_d        = 1'b1;
               boss_health_d = B_MAX;
            end
            if (state_q == ST_BOSS && boss_hit && boss_health_q != 3'd0) begin
               boss_health_d = boss_health_q - 3'd1;
            end
            // Player death takes priority over a same-cycle boss defeat.
            if (health_d == 2'd0) begin
               state_d       = ST_LOSE;
               boss_d        = 1'b0;
               boss_health_d = '0;
            end else if (state_q == ST_BOSS && boss_health_d == 3'd0) begin
               state_d = ST_WIN;
               boss_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         health_q      <= '0;
         boss_health_q <= '0;
         boss_q        <= 1'b0;
         game_over_q   <= 1'b0;
         victory_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         health_q      <= health_d;
         boss_health_q <= boss_health_d;
         boss_q        <= boss_d;
         game_over_q   <= (state_d == ST_LOSE);
         victory_q     <= (state_d == ST_WIN);
      end
   end

   assign health      = health_q;
   assign boss_health = boss_health_q;
   assign boss        = boss_q;
   assign game_over   = game_over_q;
   assign victory     = victory_q;

endmodule
